// File: rtl/deinterleaver_pkg.sv
// Shared types and constants for the 4-byte block deinterleaver.
package deinterleaver_pkg;

    // One block is four bytes; slot and read indices are 2 bits wide.
    localparam int BLOCK_BYTES = 4;
    localparam int IDX_W       = $clog2(BLOCK_BYTES);

    // Index of the last byte in a block (wr_idx/rd_idx value that ends a phase).
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_BYTES - 1);

    // Two-phase controller: collect a block, then emit it.
    typedef enum logic {
        FILL  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    // A block of bytes; element [0] is the first byte in stream order.
    typedef logic [BLOCK_BYTES-1:0][7:0] block_t;

endpackage

// File: rtl/deinterleave_map.sv
// Pure combinational inverse of the interleaver bit map.
// Output byte b, bit i comes from input byte (i/2), bit 4*(i%2)+b.
// Kept standalone so the same map can check an interleaver by round trip.
module deinterleave_map
    import deinterleaver_pkg::*;
(
    input  block_t in_bytes,
    output block_t out_bytes
);

    // Gather each output bit from its interleaved position.
    always_comb begin
        out_bytes = '0;
        for (int b = 0; b < BLOCK_BYTES; b++) begin
            for (int i = 0; i < 8; i++) begin
                out_bytes[b][i] = in_bytes[i / 2][4 * (i % 2) + b];
            end
        end
    end

endmodule

// File: rtl/deinterleaver.sv
// Block deinterleaver: collects four interleaved bytes, then streams out the
// four recovered bytes in order byte0..byte3.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. in_ready is 1 only in FILL and out_valid is 1 only in DRAIN, so the
// two sides never transfer in the same cycle. While out_valid=1 and
// out_ready=0, out_data and out_valid hold. in_valid is ignored in DRAIN.
module deinterleaver
    import deinterleaver_pkg::*;
#(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [CNT_W-1:0] blk_count,
    output state_t           state_dbg
);

    state_t           state;
    logic [IDX_W-1:0] wr_idx;
    logic [IDX_W-1:0] rd_idx;
    logic             in_ready_q;
    logic             out_valid_q;
    logic [CNT_W-1:0] cnt_q;
    block_t           slots;
    block_t           mapped;
    logic             in_xfer;
    logic             out_xfer;

    assign in_xfer  = in_valid & in_ready_q;
    assign out_xfer = out_valid_q & out_ready;

    // Controller: phase, indices, handshake flags and completed-block count.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= FILL;
            wr_idx      <= '0;
            rd_idx      <= '0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            case (state)
                FILL: begin
                    if (in_xfer) begin
                        wr_idx <= wr_idx + 1'b1;
                        if (wr_idx == LAST_IDX) begin
                            state       <= DRAIN;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        rd_idx <= rd_idx + 1'b1;
                        if (rd_idx == LAST_IDX) begin
                            state       <= FILL;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            cnt_q       <= cnt_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state       <= FILL;
                    in_ready_q  <= 1'b1;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    // Slot storage; contents survive reset since they are always rewritten
    // before being read again.
    always_ff @(posedge clk) begin
        if (!reset && state == FILL && in_xfer) begin
            slots[wr_idx] <= in_data;
        end
    end

    deinterleave_map u_map (
        .in_bytes  (slots),
        .out_bytes (mapped)
    );

    // Output byte selection; forced to zero whenever no byte is offered.
    always_comb begin
        out_data = 8'h00;
        if (out_valid_q) begin
            out_data = mapped[rd_idx];
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign blk_count = cnt_q;
    assign state_dbg = state;

endmodule

// File: tb/tb_deinterleaver.sv
// Self-checking bench for the block deinterleaver.
module tb_deinterleaver;
    import deinterleaver_pkg::*;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] blk_count;
    state_t     state_dbg;

    deinterleaver #(.CNT_W(8)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .blk_count (blk_count),
        .state_dbg (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- bookkeeping ----------------
    int         n_vec = 0;
    int         n_err = 0;
    logic [7:0] exp_q[$];
    int         pop_cnt = 0;
    logic [7:0] exp_blk = 8'd0;
    bit         mon_en = 1'b0;
    bit         rand_sink = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Forward interleave: in_k[j] = byte_(j mod 4)[2k + j div 4].
    function automatic block_t interleave(input block_t b);
        block_t r;
        r = '0;
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 8; j++)
                r[k][j] = b[j % 4][2 * k + j / 4];
        return r;
    endfunction

    function automatic block_t mk(input logic [7:0] a, input logic [7:0] b,
                                  input logic [7:0] c, input logic [7:0] d);
        block_t r;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        return r;
    endfunction

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && !reset) begin
            check("ready_vs_valid", {31'd0, in_ready}, {31'd0, !out_valid});
            if (!out_valid) check("idle_data_zero", {24'd0, out_data}, 32'd0);
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_output", {24'd0, out_data}, 32'hFFFF_FFFF);
                end else begin
                    logic [7:0] e;
                    e = exp_q.pop_front();
                    check("out_data", {24'd0, out_data}, {24'd0, e});
                    pop_cnt++;
                    if (pop_cnt == 4) begin
                        pop_cnt = 0;
                        exp_blk = exp_blk + 8'd1;
                    end
                end
            end
        end
    end

    // Optional randomized sink backpressure.
    always @(posedge clk) begin
        if (rand_sink) begin
            #1;
            out_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic push_byte(input logic [7:0] b);
        bit got;
        got = 1'b0;
        in_data  = b;
        in_valid = 1'b1;
        for (int c = 0; c < 64 && !got; c++) begin
            @(negedge clk);
            got = in_ready;
            @(posedge clk);
            #1;
        end
        check("in_accept_timeout", {31'd0, got}, 32'd1);
    endtask

    // Sends one interleaved block; expected bytes go to the scoreboard first.
    task automatic send_block(input block_t din, input block_t dexp);
        for (int e = 0; e < 4; e++) exp_q.push_back(dexp[e]);
        for (int k = 0; k < 4; k++) push_byte(din[k]);
        in_valid = 1'b0;
        // One cycle after the 4th accept: byte0 offered, input closed.
        check("latency_valid", {31'd0, out_valid}, 32'd1);
        check("latency_ready", {31'd0, in_ready}, 32'd0);
        check("latency_byte0", {24'd0, out_data}, {24'd0, dexp[0]});
    endtask

    task automatic wait_drain();
        for (int c = 0; c < 400 && exp_q.size() != 0; c++) @(posedge clk);
        #1;
        check("drain_timeout", exp_q.size(), 32'd0);
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        pop_cnt = 0;
        exp_blk = 8'd0;
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_data",  {24'd0, out_data},  32'd0);
        check("rst_blk_count", {24'd0, blk_count}, 32'd0);
        check("rst_state",     {31'd0, state_dbg}, {31'd0, FILL});
    endtask

    // ---------------- test ----------------
    typedef struct {
        block_t din;
        block_t dout;
    } vec_t;

    vec_t   tbl[3];
    block_t rb;
    block_t ab;

    initial begin
        tbl[0].din = mk(8'hA8, 8'h66, 8'h00, 8'h40); tbl[0].dout = mk(8'h00, 8'h0E, 8'h8C, 8'h03);
        tbl[1].din = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF); tbl[1].dout = mk(8'hFF, 8'hFF, 8'hFF, 8'hFF);
        tbl[2].din = mk(8'h01, 8'h00, 8'h00, 8'h00); tbl[2].dout = mk(8'h01, 8'h00, 8'h00, 8'h00);

        reset = 1'b1; in_valid = 1'b0; in_data = 8'h00; out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        do_reset();
        mon_en = 1'b1;

        // Known vectors, free-flowing sink.
        for (int v = 0; v < 3; v++) begin
            send_block(tbl[v].din, tbl[v].dout);
            wait_drain();
            check("tbl_blk_count", {24'd0, blk_count}, {24'd0, exp_blk});
        end
        check("blk_after_tbl", {24'd0, blk_count}, 32'd3);

        // Backpressure in DRAIN with in_valid held high on the next block's first byte.
        out_ready = 1'b0;
        send_block(tbl[0].din, tbl[0].dout);
        rb = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
        ab = interleave(rb);
        in_data  = ab[0];
        in_valid = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_hold_data",  {24'd0, out_data},  32'h00);
            check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",   {31'd0, in_ready},  32'd0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send_block(ab, rb);
        wait_drain();
        check("bp_blk_count", {24'd0, blk_count}, 32'd5);

        // Reset after two input bytes discards the partial block.
        push_byte(8'h11);
        push_byte(8'h22);
        do_reset();
        send_block(tbl[0].din, tbl[0].dout);
        wait_drain();
        check("blk_after_reset", {24'd0, blk_count}, 32'd1);

        // Reset in the middle of DRAIN.
        out_ready = 1'b0;
        send_block(tbl[1].din, tbl[1].dout);
        @(posedge clk);
        #1;
        do_reset();
        out_ready = 1'b1;

        // Random blocks with random sink backpressure.
        rand_sink = 1'b1;
        for (int n = 0; n < 40; n++) begin
            rb = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            send_block(interleave(rb), rb);
        end
        wait_drain();
        rand_sink = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        check("rand_blk_count", {24'd0, blk_count}, 32'd40);

        // 256 back-to-back blocks from reset wrap the counter to zero.
        do_reset();
        for (int n = 0; n < 256; n++) begin
            rb = mk(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
                    8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            send_block(interleave(rb), rb);
            if (n == 254) begin
                wait_drain();
                check("blk_255", {24'd0, blk_count}, 32'd255);
            end
        end
        wait_drain();
        check("blk_wrap", {24'd0, blk_count}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
